// File: rtl/grf_writeback_if.sv
// rtl/grf_writeback_if.sv - WB-stage write request, ID-stage read ports and commit report of grf_writeback
interface grf_writeback_if;
  logic        reg_write;
  logic [1:0]  mem_to_reg;
  logic [1:0]  reg_dst;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] mem_data;
  logic [31:0] pc;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  modport master (
    output reg_write, mem_to_reg, reg_dst, rt, rd, alu_result, mem_data, pc, ra1, ra2,
    input  rd1, rd2, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  reg_write, mem_to_reg, reg_dst, rt, rd, alu_result, mem_data, pc, ra1, ra2,
    output rd1, rd2, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/grf_writeback.sv
// rtl/grf_writeback.sv - 32x32 register file with writeback decode; optional GRF_BYPASS_EN forwards pending writes to reads
module grf_writeback #(
  parameter int unsigned RA_INDEX = 31
) (
  input logic             clk,
  input logic             reset,
  grf_writeback_if.slave  bus
);

  localparam logic [4:0] RA_ADDR = 5'(RA_INDEX);

  logic [31:0] regs [32];
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        dst_ok;
  logic        src_ok;
  logic        commit;
  logic        wb_en_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;

  always_comb begin
    waddr  = 5'd0;
    dst_ok = 1'b1;
    case (bus.reg_dst)
      2'd0:    waddr = bus.rt;
      2'd1:    waddr = bus.rd;
      2'd2:    waddr = RA_ADDR;
      default: dst_ok = 1'b0;
    endcase
  end

  always_comb begin
    wdata  = 32'd0;
    src_ok = 1'b1;
    case (bus.mem_to_reg)
      2'd0:    wdata = bus.alu_result;
      2'd1:    wdata = bus.mem_data;
      2'd2:    wdata = bus.pc + 32'd8;
      default: src_ok = 1'b0;
    endcase
  end

  // Writes to r0 are dropped here so they neither touch the array nor report wb_en.
  assign commit = !reset && bus.reg_write && dst_ok && src_ok && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
      wb_en_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      wb_en_q <= commit;
      if (commit) begin
        regs[waddr] <= wdata;
        wb_addr_q   <= waddr;
        wb_data_q   <= wdata;
      end
    end
  end

  logic [31:0] arr1;
  logic [31:0] arr2;

  assign arr1 = (bus.ra1 == 5'd0) ? 32'd0 : regs[bus.ra1];
  assign arr2 = (bus.ra2 == 5'd0) ? 32'd0 : regs[bus.ra2];

`ifdef GRF_BYPASS_EN
  assign bus.rd1 = (commit && (bus.ra1 == waddr)) ? wdata : arr1;
  assign bus.rd2 = (commit && (bus.ra2 == waddr)) ? wdata : arr2;
`else
  assign bus.rd1 = arr1;
  assign bus.rd2 = arr2;
`endif

  assign bus.wb_en   = wb_en_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_grf_writeback.sv
// tb/tb_grf_writeback.sv - table-driven directed bench for grf_writeback
module tb_grf_writeback;

  logic clk = 1'b0;
  logic reset;
  grf_writeback_if bus();

  grf_writeback #(.RA_INDEX(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [1:0]  reg_dst;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        exp_wb_en;
    logic [4:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
  } vec_t;

  vec_t vecs [10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset          = v.rst;
    bus.reg_write  = v.reg_write;
    bus.mem_to_reg = v.mem_to_reg;
    bus.reg_dst    = v.reg_dst;
    bus.rt         = v.rt;
    bus.rd         = v.rd;
    bus.alu_result = v.alu_result;
    bus.mem_data   = v.mem_data;
    bus.pc         = v.pc;
    bus.ra1        = v.ra1;
    bus.ra2        = v.ra2;
  endtask

  initial begin
    logic [31:0] exp_pre;

    // rst, we, m2r, dst, rt, rd, alu, mem, pc, ra1, ra2 | wb_en, wb_addr, wb_data, rd1, rd2
    vecs[0] = '{1'b1, 1'b1, 2'd0, 2'd1, 5'd0, 5'd3,  32'h55,       32'h0,        32'h0,        5'd3,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b0, 1'b1, 2'd0, 2'd1, 5'd0, 5'd5,  32'h1234,     32'h0,        32'h0,        5'd5,  5'd5,  1'b1, 5'd5,  32'h1234,     32'h1234,     32'h1234};
    vecs[2] = '{1'b0, 1'b1, 2'd2, 2'd2, 5'd0, 5'd0,  32'h0,        32'h0,        32'h00003000, 5'd31, 5'd5,  1'b1, 5'd31, 32'h00003008, 32'h00003008, 32'h1234};
    vecs[3] = '{1'b0, 1'b1, 2'd0, 2'd0, 5'd0, 5'd7,  32'hFFFFFFFF, 32'h0,        32'h0,        5'd0,  5'd31, 1'b0, 5'd31, 32'h00003008, 32'h0,        32'h00003008};
    vecs[4] = '{1'b0, 1'b1, 2'd1, 2'd0, 5'd8, 5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        5'd8,  5'd0,  1'b1, 5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 2'd0, 2'd3, 5'd9, 5'd9,  32'h77,       32'h0,        32'h0,        5'd9,  5'd8,  1'b0, 5'd8,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b1, 2'd3, 2'd1, 5'd0, 5'd9,  32'h88,       32'h0,        32'h0,        5'd9,  5'd5,  1'b0, 5'd8,  32'hDEADBEEF, 32'h0,        32'h1234};
    vecs[7] = '{1'b0, 1'b0, 2'd0, 2'd1, 5'd0, 5'd9,  32'h99,       32'h0,        32'h0,        5'd9,  5'd9,  1'b0, 5'd8,  32'hDEADBEEF, 32'h0,        32'h0};
    vecs[8] = '{1'b0, 1'b1, 2'd2, 2'd1, 5'd0, 5'd10, 32'h0,        32'h0,        32'hFFFFFFFC, 5'd10, 5'd31, 1'b1, 5'd10, 32'h00000004, 32'h00000004, 32'h00003008};
    vecs[9] = '{1'b1, 1'b0, 2'd0, 2'd1, 5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        5'd8,  5'd31, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d wb_en", i),   {31'd0, bus.wb_en}, {31'd0, vecs[i].exp_wb_en});
      check($sformatf("v%0d wb_addr", i), {27'd0, bus.wb_addr}, {27'd0, vecs[i].exp_wb_addr});
      check($sformatf("v%0d wb_data", i), bus.wb_data, vecs[i].exp_wb_data);
      reset         = 1'b0;
      bus.reg_write = 1'b0;
      #1;
      check($sformatf("v%0d rd1", i), bus.rd1, vecs[i].exp_rd1);
      check($sformatf("v%0d rd2", i), bus.rd2, vecs[i].exp_rd2);
    end

    // Every address reads zero after the reset edge.
    for (int a = 0; a < 32; a++) begin
      bus.ra1 = 5'(a);
      bus.ra2 = 5'(31 - a);
      #1;
      check($sformatf("post-reset rd1[%0d]", a), bus.rd1, 32'h0);
      check($sformatf("post-reset rd2[%0d]", 31 - a), bus.rd2, 32'h0);
    end

    // Seed r8 with a known old value before the same-cycle read-during-write case.
    @(negedge clk);
    bus.reg_write  = 1'b1;
    bus.reg_dst    = 2'd1;
    bus.rd         = 5'd8;
    bus.mem_to_reg = 2'd0;
    bus.alu_result = 32'h11;
    @(posedge clk);
    #1;
    check("seed wb_en", {31'd0, bus.wb_en}, 32'd1);

    @(negedge clk);
    bus.alu_result = 32'hAA;
    bus.ra1        = 5'd8;
    bus.ra2        = 5'd8;
    #1;
`ifdef GRF_BYPASS_EN
    exp_pre = 32'hAA;
`else
    exp_pre = 32'h11;
`endif
    check("same-cycle rd2", bus.rd2, exp_pre);
    check("same-cycle rd1", bus.rd1, exp_pre);
    @(posedge clk);
    #1;
    bus.reg_write = 1'b0;
    #1;
    check("after-edge rd2", bus.rd2, 32'hAA);
    check("after-edge wb_data", bus.wb_data, 32'hAA);

    // A write to r0 must not be forwarded even under bypass.
    @(negedge clk);
    bus.reg_write  = 1'b1;
    bus.reg_dst    = 2'd0;
    bus.rt         = 5'd0;
    bus.alu_result = 32'hFFFFFFFF;
    bus.ra1        = 5'd0;
    bus.ra2        = 5'd0;
    #1;
    check("r0 same-cycle rd1", bus.rd1, 32'h0);
    @(posedge clk);
    #1;
    check("r0 wb_en", {31'd0, bus.wb_en}, 32'd0);
    check("r0 wb_addr held", {27'd0, bus.wb_addr}, 32'd8);
    bus.reg_write = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grf_writeback.md
GRF_WRITEBACK -- requirements
Module: grf_writeback

Interface
REQ-001 SHALL have parameter RA_INDEX, default 31, which is the link-register index used for jal writes.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port reg_write, input, 1 bit: WB-stage register write enable.
REQ-005 SHALL have port mem_to_reg, input, 2 bits: write-data select (0 ALU, 1 memory, 2 link).
REQ-006 SHALL have port reg_dst, input, 2 bits: destination select (0 rt, 1 rd, 2 RA_INDEX).
REQ-007 SHALL have ports rt and rd, input, 5 bits each: WB-stage instruction register fields.
REQ-008 SHALL have ports alu_result, mem_data and pc, input, 32 bits each: WB-stage ALU result, load data and instruction PC.
REQ-009 SHALL have ports ra1 and ra2, input, 5 bits each: ID-stage read addresses.
REQ-010 SHALL have ports rd1 and rd2, output, 32 bits each: read data for ra1 and ra2.
REQ-011 SHALL have port wb_en, output, 1 bit: registered flag, set when a write committed on the previous edge.
REQ-012 SHALL have ports wb_addr (5 bits) and wb_data (32 bits), output: registered address and data of the last committed write.

Function
REQ-013 SHALL hold 32 x 32-bit registers; register 0 reads 0 always and is never written.
REQ-014 SHALL decode waddr as: reg_dst 0 -> rt; 1 -> rd; 2 -> RA_INDEX; 3 -> no write.
REQ-015 SHALL decode wdata as: mem_to_reg 0 -> alu_result; 1 -> mem_data; 2 -> pc + 8 (mod 2^32); 3 -> no write.
REQ-016 SHALL define a write as committing on a rising edge iff reset=0, reg_write=1, reg_dst!=3, mem_to_reg!=3 and waddr!=0.
REQ-017 SHALL drive rd1/rd2 combinationally from the array, with zero latency for reads of already-committed data.
REQ-018 SHALL, on a commit edge, set wb_en=1, wb_addr=waddr and wb_data=wdata; on a non-commit edge it SHALL set wb_en=0 and hold wb_addr and wb_data.
REQ-019 SHALL, for an attempted write to register 0, leave the array unchanged and set wb_en=0.
REQ-020 SHALL, when ra1==ra2, return identical data on both ports, including under bypass.

Reset
REQ-021 SHALL clear all 32 registers, wb_en, wb_addr and wb_data to 0 on a clock edge with reset=1.
REQ-022 SHALL ignore a write requested in the same cycle as reset; reset has priority.
REQ-023 SHALL drive rd1/rd2 to 0 for every address after a reset edge, until a new write commits.

Configuration
REQ-024 SHALL implement macro GRF_BYPASS_EN; when it is defined, rd1 (and likewise rd2) SHALL equal wdata in any cycle where a commit is pending (REQ-016 conditions true) and ra1==waddr.
REQ-025 SHALL, without GRF_BYPASS_EN, return only array contents, so same-cycle reads see the old value until after the edge.

Verification
REQ-026 Bench SHALL cover: reset, then reg_write=1, reg_dst=1, rd=5, mem_to_reg=0, alu_result=0x1234 -> after the edge, ra1=5 gives rd1=0x1234 and wb_en=1, wb_addr=5, wb_data=0x1234.
REQ-027 Bench SHALL cover: reg_dst=2, mem_to_reg=2, pc=0x00003000 -> register 31 = 0x00003008.
REQ-028 Bench SHALL cover: reg_dst=0, rt=0, alu_result=0xFFFFFFFF -> rd1 for ra1=0 stays 0 and wb_en=0.
REQ-029 Bench SHALL cover: same-cycle write r8=0xAA with ra2=8 -> rd2=0xAA before the edge with GRF_BYPASS_EN, and the old value without it.
REQ-030 Bench SHALL cover: reset=1 together with a write of r3=0x55 -> r3=0 and wb_en=0 after the edge.
REQ-031 Bench SHALL cover: pc=0xFFFFFFFC with mem_to_reg=2 -> written value 0x00000004 (wrap-around).
